// File: rtl/system_controller_pkg.sv
// Definitions shared by the UART receiver and transmitter controllers:
// command codes, fixed ALU operand addresses and the receiver FSM encoding.
package system_controller_pkg;

  localparam logic [7:0] CMD_REG_WRITE       = 8'hAA;
  localparam logic [7:0] CMD_REG_READ        = 8'hBB;
  localparam logic [7:0] CMD_ALU_OPERANDS    = 8'hCC;
  localparam logic [7:0] CMD_ALU_NO_OPERANDS = 8'hDD;

  localparam int unsigned OPERAND_A_ADDR = 0;
  localparam int unsigned OPERAND_B_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WRITE_ADDRESS = 3'd1,
    WRITE_DATA    = 3'd2,
    READ_ADDRESS  = 3'd3,
    OPERAND_A     = 3'd4,
    OPERAND_B     = 3'd5,
    ALU_FUNCTION  = 3'd6
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_controller.sv
// Decodes command bytes from the UART receiver into register-file and ALU
// strobes; every output is a flop updated one cycle after the accepted byte.
module uart_receiver_controller #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALU_FUNCTION_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         received_data,
  input  logic                          received_data_valid,
  input  logic                          enable,
  output logic [ADDRESS_WIDTH-1:0]      address,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          read_enable,
  output logic                          ALU_enable,
  output logic [ALU_FUNCTION_WIDTH-1:0] ALU_function,
  output logic                          clock_gate_enable
);

  import system_controller_pkg::*;

  rx_state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]      address_q, address_d;
  logic                          write_enable_q, write_enable_d;
  logic [DATA_WIDTH-1:0]         write_data_q, write_data_d;
  logic                          read_enable_q, read_enable_d;
  logic                          alu_enable_q, alu_enable_d;
  logic [ALU_FUNCTION_WIDTH-1:0] alu_function_q, alu_function_d;
  logic                          clock_gate_enable_q, clock_gate_enable_d;
  logic                          gate_tail_q, gate_tail_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= IDLE;
      address_q           <= '0;
      write_enable_q      <= 1'b0;
      write_data_q        <= '0;
      read_enable_q       <= 1'b0;
      alu_enable_q        <= 1'b0;
      alu_function_q      <= '0;
      clock_gate_enable_q <= 1'b0;
      gate_tail_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      address_q           <= address_d;
      write_enable_q      <= write_enable_d;
      write_data_q        <= write_data_d;
      read_enable_q       <= read_enable_d;
      alu_enable_q        <= alu_enable_d;
      alu_function_q      <= alu_function_d;
      clock_gate_enable_q <= clock_gate_enable_d;
      gate_tail_q         <= gate_tail_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    address_d           = address_q;
    write_enable_d      = 1'b0;
    write_data_d        = write_data_q;
    read_enable_d       = 1'b0;
    alu_enable_d        = 1'b0;
    alu_function_d      = alu_function_q;
    clock_gate_enable_d = clock_gate_enable_q;
    gate_tail_d         = alu_enable_q;

    // Gated clock stays on for one cycle after the ALU start strobe.
    if (gate_tail_q) clock_gate_enable_d = 1'b0;

    if (received_data_valid) begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            if (received_data == DATA_WIDTH'(CMD_REG_WRITE)) begin
              state_d = WRITE_ADDRESS;
            end else if (received_data == DATA_WIDTH'(CMD_REG_READ)) begin
              state_d = READ_ADDRESS;
            end else if (received_data == DATA_WIDTH'(CMD_ALU_OPERANDS)) begin
              state_d             = OPERAND_A;
              clock_gate_enable_d = 1'b1;
              gate_tail_d         = 1'b0;
            end else if (received_data == DATA_WIDTH'(CMD_ALU_NO_OPERANDS)) begin
              state_d             = ALU_FUNCTION;
              clock_gate_enable_d = 1'b1;
              gate_tail_d         = 1'b0;
            end
          end
        end
        WRITE_ADDRESS: begin
          address_d = received_data[ADDRESS_WIDTH-1:0];
          state_d   = WRITE_DATA;
        end
        WRITE_DATA: begin
          write_data_d   = received_data;
          write_enable_d = 1'b1;
          state_d        = IDLE;
        end
        READ_ADDRESS: begin
          address_d     = received_data[ADDRESS_WIDTH-1:0];
          read_enable_d = 1'b1;
          state_d       = IDLE;
        end
        OPERAND_A: begin
          address_d      = ADDRESS_WIDTH'(OPERAND_A_ADDR);
          write_data_d   = received_data;
          write_enable_d = 1'b1;
          state_d        = OPERAND_B;
        end
        OPERAND_B: begin
          address_d      = ADDRESS_WIDTH'(OPERAND_B_ADDR);
          write_data_d   = received_data;
          write_enable_d = 1'b1;
          state_d        = ALU_FUNCTION;
        end
        ALU_FUNCTION: begin
          alu_function_d = received_data[ALU_FUNCTION_WIDTH-1:0];
          alu_enable_d   = 1'b1;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign address           = address_q;
  assign write_enable      = write_enable_q;
  assign write_data        = write_data_q;
  assign read_enable       = read_enable_q;
  assign ALU_enable        = alu_enable_q;
  assign ALU_function      = alu_function_q;
  assign clock_gate_enable = clock_gate_enable_q;

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Directed bench for uart_receiver_controller: command sequences with
// hand-computed register-file/ALU strobe expectations.
module tb_uart_receiver_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_valid = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] address;
  logic       write_enable;
  logic [7:0] write_data;
  logic       read_enable;
  logic       ALU_enable;
  logic [3:0] ALU_function;
  logic       clock_gate_enable;

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;
  int re_pulses = 0;
  int alu_pulses = 0;

  uart_receiver_controller #(
    .DATA_WIDTH(8),
    .ADDRESS_WIDTH(4),
    .ALU_FUNCTION_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .received_data(received_data),
    .received_data_valid(received_data_valid),
    .enable(enable),
    .address(address),
    .write_enable(write_enable),
    .write_data(write_data),
    .read_enable(read_enable),
    .ALU_enable(ALU_enable),
    .ALU_function(ALU_function),
    .clock_gate_enable(clock_gate_enable)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable) we_pulses++;
    if (read_enable)  re_pulses++;
    if (ALU_enable)   alu_pulses++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, where the
  // registered response to the byte is visible.
  task automatic send_byte(input logic [7:0] b);
    received_data       = b;
    received_data_valid = 1'b1;
    @(negedge clk);
    received_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Packs {cg, alu_en, re, we} for compact strobe comparisons.
  function automatic logic [3:0] strobes();
    return {clock_gate_enable, ALU_enable, read_enable, write_enable};
  endfunction

  initial begin
    // Reset state
    #12;
    check_val("rst_strobes", {28'd0, strobes()}, 32'h0);
    check_val("rst_addr", {28'd0, address}, 32'h0);
    check_val("rst_wdata", {24'd0, write_data}, 32'h0);
    check_val("rst_func", {28'd0, ALU_function}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;

    // Register write, with idle gaps between bytes
    send_byte(8'hAA);
    check_val("wr_after_cmd", {28'd0, strobes()}, 32'h0);
    idle(3);
    send_byte(8'h05);
    check_val("wr_after_addr", {28'd0, strobes()}, 32'h0);
    idle(2);
    send_byte(8'h3C);
    check_val("wr_strobe", {28'd0, strobes()}, 32'h1);
    check_val("wr_addr", {28'd0, address}, 32'h5);
    check_val("wr_data", {24'd0, write_data}, 32'h3C);
    idle(1);
    check_val("wr_one_cycle", {28'd0, strobes()}, 32'h0);
    check_val("wr_addr_hold", {28'd0, address}, 32'h5);

    // Register read, upper nibble of the address byte dropped
    send_byte(8'hBB);
    send_byte(8'hF2);
    check_val("rd_strobe", {28'd0, strobes()}, 32'h2);
    check_val("rd_addr", {28'd0, address}, 32'h2);
    idle(1);
    check_val("rd_one_cycle", {28'd0, strobes()}, 32'h0);

    // ALU with operands
    send_byte(8'hCC);
    check_val("alu_cg_on", {28'd0, strobes()}, 32'h8);
    send_byte(8'h12);
    check_val("opa_strobe", {28'd0, strobes()}, 32'h9);
    check_val("opa_addr", {28'd0, address}, 32'h0);
    check_val("opa_data", {24'd0, write_data}, 32'h12);
    send_byte(8'h34);
    check_val("opb_strobe", {28'd0, strobes()}, 32'h9);
    check_val("opb_addr", {28'd0, address}, 32'h1);
    check_val("opb_data", {24'd0, write_data}, 32'h34);
    send_byte(8'h01);
    check_val("alu_strobe", {28'd0, strobes()}, 32'hC);
    check_val("alu_func", {28'd0, ALU_function}, 32'h1);
    idle(1);
    check_val("alu_cg_tail", {28'd0, strobes()}, 32'h8);
    idle(1);
    check_val("alu_cg_off", {28'd0, strobes()}, 32'h0);
    check_val("alu_func_hold", {28'd0, ALU_function}, 32'h1);

    // Blocked while enable is low
    enable = 1'b0;
    send_byte(8'hDD);
    check_val("blk_no_cg", {28'd0, strobes()}, 32'h0);
    send_byte(8'h02);
    check_val("blk_no_alu", {28'd0, strobes()}, 32'h0);
    check_val("blk_func_hold", {28'd0, ALU_function}, 32'h1);

    // In-flight write completes after enable drops
    enable = 1'b1;
    send_byte(8'hAA);
    enable = 1'b0;
    send_byte(8'h07);
    send_byte(8'h99);
    check_val("inflight_strobe", {28'd0, strobes()}, 32'h1);
    check_val("inflight_addr", {28'd0, address}, 32'h7);
    check_val("inflight_data", {24'd0, write_data}, 32'h99);
    enable = 1'b1;

    // Junk byte in IDLE, then reset mid-command
    send_byte(8'h55);
    check_val("junk_ignored", {28'd0, strobes()}, 32'h0);
    send_byte(8'hCC);
    check_val("junk_then_cmd", {28'd0, strobes()}, 32'h8);
    send_byte(8'h10);
    check_val("pre_rst_write", {28'd0, strobes()}, 32'h9);
    check_val("pre_rst_data", {24'd0, write_data}, 32'h10);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst_strobes", {28'd0, strobes()}, 32'h0);
    check_val("async_rst_addr", {28'd0, address}, 32'h0);
    check_val("async_rst_wdata", {24'd0, write_data}, 32'h0);
    check_val("async_rst_func", {28'd0, ALU_function}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'h34);
    check_val("abandoned_opb", {28'd0, strobes()}, 32'h0);
    send_byte(8'hBB);
    check_val("post_rst_cmd", {28'd0, strobes()}, 32'h0);
    send_byte(8'h03);
    check_val("post_rst_read", {28'd0, strobes()}, 32'h2);
    check_val("post_rst_addr", {28'd0, address}, 32'h3);
    idle(3);
    check_val("final_quiet", {28'd0, strobes()}, 32'h0);

    check_val("we_pulse_count", we_pulses, 5);
    check_val("re_pulse_count", re_pulses, 2);
    check_val("alu_pulse_count", alu_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_receiver_controller.md
UART_RECEIVER_CONTROLLER -- requirements
Module: UART_receiver_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the received byte width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, meaning the register file address width.
REQ-003 SHALL have parameter ALU_FUNCTION_WIDTH, default 4, meaning the ALU opcode width.
REQ-004 SHALL have port clk, input, 1 bit: the single reference clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port received_data, input, DATA_WIDTH bits: synchronized byte from the UART receiver.
REQ-007 SHALL have port received_data_valid, input, 1 bit: one-cycle pulse qualifying received_data.
REQ-008 SHALL have port enable, input, 1 bit: driven by UART_transmitter_controller; low blocks new commands.
REQ-009 SHALL have port address, output, ADDRESS_WIDTH bits: register file address.
REQ-010 SHALL have port write_enable, output, 1 bit: one-cycle register file write strobe.
REQ-011 SHALL have port write_data, output, DATA_WIDTH bits: register file write data.
REQ-012 SHALL have port read_enable, output, 1 bit: one-cycle register file read strobe.
REQ-013 SHALL have port ALU_enable, output, 1 bit: one-cycle ALU start strobe.
REQ-014 SHALL have port ALU_function, output, ALU_FUNCTION_WIDTH bits: ALU opcode.
REQ-015 SHALL have port clock_gate_enable, output, 1 bit: enables the gated ALU clock.

Function
REQ-016 SHALL decode command bytes: 0xAA register write, 0xBB register read, 0xCC ALU with operands, 0xDD ALU without operands.
REQ-017 SHALL implement FSM states IDLE, WRITE_ADDRESS, WRITE_DATA, READ_ADDRESS, OPERAND_A, OPERAND_B and ALU_FUNCTION.
REQ-018 SHALL advance state only on cycles with received_data_valid high; with valid low, state and outputs hold, strobes excepted.
REQ-019 SHALL, in IDLE, accept a command byte only when enable is high; bytes arriving while enable is low SHALL be dropped.
REQ-020 SHALL, in IDLE, drop any byte other than the four command codes and stay in IDLE.
REQ-021 SHALL, in non-IDLE states, accept bytes regardless of enable, so an in-flight command always completes.
REQ-022 SHALL implement transitions: 0xAA -> WRITE_ADDRESS -> WRITE_DATA -> IDLE; 0xBB -> READ_ADDRESS -> IDLE; 0xCC -> OPERAND_A -> OPERAND_B -> ALU_FUNCTION -> IDLE; 0xDD -> ALU_FUNCTION -> IDLE.
REQ-023 SHALL register address from byte bits [ADDRESS_WIDTH-1:0]; upper bits are ignored.
REQ-024 SHALL register ALU_function from byte bits [ALU_FUNCTION_WIDTH-1:0]; upper bits are ignored.
REQ-025 SHALL pulse write_enable for exactly one cycle, the cycle after the WRITE_DATA byte is accepted, with write_data equal to that byte and address held.
REQ-026 SHALL pulse read_enable for exactly one cycle, the cycle after the READ_ADDRESS byte is accepted, with address equal to that byte.
REQ-027 SHALL, for each operand byte, write OPERAND_A to address 0x0 and OPERAND_B to address 0x1 using the one-cycle write_enable timing of REQ-025.
REQ-028 SHALL pulse ALU_enable for exactly one cycle, the cycle after the function byte is accepted.
REQ-029 SHALL raise clock_gate_enable the cycle after 0xCC or 0xDD is accepted and hold it high through the ALU_enable cycle plus one further cycle.
REQ-030 SHALL register every output (no combinational input-to-output paths); latency from valid byte to strobe is exactly 1 cycle.
REQ-031 SHALL never assert write_enable, read_enable and ALU_enable in the same cycle.

Reset
REQ-032 SHALL, on reset low, immediately force IDLE and drive all outputs to 0, including address, write_data and ALU_function.
REQ-033 SHALL abandon a partial command on reset mid-operation; no strobe for it SHALL follow reset release.

Structure
REQ-034 SHALL take command codes, operand addresses (0x0, 0x1) and state encodings from shared package system_controller_pkg, which is also used by UART_transmitter_controller.
REQ-035 SHALL be a single module with no sub-modules; the FSM and output registers are in one block.

Verification
REQ-036 Write: enable=1; bytes 0xAA, 0x05, 0x3C -> one write_enable pulse, address=0x5, write_data=0x3C.
REQ-037 Read: bytes 0xBB, 0xF2 -> one read_enable pulse, address=0x2 (upper nibble ignored); no write_enable.
REQ-038 ALU with operands: bytes 0xCC, 0x12, 0x34, 0x01 -> write 0x12 to 0x0, write 0x34 to 0x1, then ALU_enable with ALU_function=0x1; clock_gate_enable high until one cycle after ALU_enable.
REQ-039 Blocking: enable=0; bytes 0xDD, 0x02 -> no strobes. Then enable=1 and 0xAA, with enable dropped to 0 before 0x07, 0x99 -> write still occurs to address 0x7 with data 0x99.
REQ-040 Junk and reset: byte 0x55 in IDLE -> ignored. Then 0xCC, 0x10, with reset pulsed low -> all outputs 0 immediately. After release, 0xBB, 0x03 -> only read_enable with address=0x3.
